// File: rtl/temporal_window_scheduler_pkg.sv
// Shared definitions for the temporal window scheduler and its datapath:
// state encoding, default window geometry and a width helper.
package temporal_window_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ACCUM = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEFAULT_WINDOW_LEN     = 5;
    localparam int DEFAULT_NGRAM_SIZE     = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int ceil_log2(input int value);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= value) return w;
        end
        return 31;
    endfunction

endpackage

// File: rtl/temporal_window_scheduler_idle_watchdog.sv
// Counts consecutive enabled cycles without a kick and flags the cycle in
// which the count reaches TIMEOUT_CYCLES.
module idle_watchdog
    import temporal_window_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic Clk_CI,
    input  logic Reset_RI,
    input  logic Enable_SI,
    input  logic Kick_SI,
    output logic Expired_SO
);

    localparam int CW = ceil_log2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // The stalled cycle that would make the count TIMEOUT_CYCLES is the expiry.
    assign Expired_SO = Enable_SI && !Kick_SI && (count == LAST);

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI || !Enable_SI || Kick_SI || Expired_SO) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/temporal_window_scheduler.sv
// Window sequencer for the temporal encoder: drives n-gram and accumulator
// strobes per sample and hands each window to the AM. TEMPORAL_TIMEOUT_EN adds an idle watchdog.
module temporal_window_scheduler
    import temporal_window_scheduler_pkg::*;
#(
    parameter int WINDOW_LEN     = DEFAULT_WINDOW_LEN,
    parameter int NGRAM_SIZE     = DEFAULT_NGRAM_SIZE,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        Clk_CI,
    input  logic        Reset_RI,
    input  logic        ValidIn_SI,
    output logic        ReadyOut_SO,
    input  logic        ReadyIn_SI,
    output logic        ValidOut_SO,
    input  logic        ClearIn_SI,
    output logic        NGramShiftEN_SO,
    output logic        NGramClear_SO,
    output logic        AccumEN_SO,
    output logic        FirstHypervector_SO,
    output logic        Timeout_SO,
    output logic [15:0] WindowCntr_SO,
    output logic [2:0]  State_SO
);

    // Upstream: a sample moves when ValidIn_SI && ReadyOut_SO in the same cycle.
    // Downstream: a window moves when ValidOut_SO && ReadyIn_SI; ValidOut_SO holds until then.
    localparam int IW = ceil_log2(WINDOW_LEN);
    localparam logic [IW:0] WL = (IW + 1)'(WINDOW_LEN);
    localparam logic [IW:0] NG = (IW + 1)'(NGRAM_SIZE);

    state_t        state;
    logic [IW-1:0] idx;
    logic [15:0]   window_cntr;
    logic          accum_en;
    logic          first_hv;
    logic          accept;
    logic          abort;
    logic          handshake;
    logic          expired;
    logic [IW:0]   count_after;
    logic          is_last;
    logic          accum_hit;
    logic          first_hit;
    logic          fill_hit;

`ifdef TEMPORAL_TIMEOUT_EN
    idle_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .Clk_CI    (Clk_CI),
        .Reset_RI  (Reset_RI),
        .Enable_SI ((state == FILL) || (state == ACCUM)),
        .Kick_SI   (accept),
        .Expired_SO(expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign ReadyOut_SO = (state == IDLE) || (state == FILL) || (state == ACCUM);
    assign ValidOut_SO = (state == DONE);

    // Clear (and a watchdog expiry) outrank both the sample and the AM handshake.
    assign abort     = ClearIn_SI || expired;
    assign accept    = ValidIn_SI && ReadyOut_SO && !ClearIn_SI;
    assign handshake = ValidOut_SO && ReadyIn_SI && !abort;

    assign NGramShiftEN_SO     = accept;
    assign NGramClear_SO       = abort || handshake;
    assign AccumEN_SO          = accum_en;
    assign FirstHypervector_SO = first_hv;
    assign Timeout_SO          = expired;
    assign WindowCntr_SO       = window_cntr;
    assign State_SO            = state;

    // count_after is the number of samples in the window including this one.
    assign count_after = {1'b0, idx} + 1'b1;
    assign is_last     = (count_after == WL);
    assign accum_hit   = (count_after >= NG);
    assign first_hit   = (count_after == NG);
    assign fill_hit    = ((count_after + 1'b1) >= NG);

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state       <= IDLE;
            idx         <= '0;
            window_cntr <= '0;
            accum_en    <= 1'b0;
            first_hv    <= 1'b0;
        end else begin
            accum_en <= accept && !expired && accum_hit;
            first_hv <= accept && !expired && first_hit;
            if (abort) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE, FILL, ACCUM: begin
                        if (accept) begin
                            idx <= is_last ? '0 : count_after[IW-1:0];
                            if (is_last) begin
                                state <= FLUSH;
                            end else if ((state == ACCUM) || ((state == FILL) && fill_hit) ||
                                         ((state == IDLE) && (NGRAM_SIZE == 1))) begin
                                state <= ACCUM;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                    FLUSH: state <= DONE;
                    DONE: begin
                        if (handshake) begin
                            state       <= IDLE;
                            idx         <= '0;
                            window_cntr <= window_cntr + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_temporal_window_scheduler.sv
// Directed bench for temporal_window_scheduler (default geometry plus an
// NGRAM_SIZE=1 instance); TEMPORAL_TIMEOUT_EN selects the watchdog expectations.
module tb_temporal_window_scheduler;
    import temporal_window_scheduler_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic        clear_in;
    logic        ready_out, valid_out, shift_en, ngram_clear, accum_en, first_hv, timeout;
    logic [15:0] window_cntr;
    logic [2:0]  state;
    logic        n1_ready_out, n1_valid_out, n1_shift_en, n1_ngram_clear;
    logic        n1_accum_en, n1_first_hv, n1_timeout;
    logic [15:0] n1_window_cntr;
    logic [2:0]  n1_state;

    int tests;
    int failures;

    temporal_window_scheduler #(
        .WINDOW_LEN(5), .NGRAM_SIZE(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(valid_in), .ReadyOut_SO(ready_out),
        .ReadyIn_SI(ready_in), .ValidOut_SO(valid_out), .ClearIn_SI(clear_in),
        .NGramShiftEN_SO(shift_en), .NGramClear_SO(ngram_clear), .AccumEN_SO(accum_en),
        .FirstHypervector_SO(first_hv), .Timeout_SO(timeout), .WindowCntr_SO(window_cntr),
        .State_SO(state)
    );

    temporal_window_scheduler #(
        .WINDOW_LEN(3), .NGRAM_SIZE(1), .TIMEOUT_CYCLES(8)
    ) dut_n1 (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(valid_in), .ReadyOut_SO(n1_ready_out),
        .ReadyIn_SI(ready_in), .ValidOut_SO(n1_valid_out), .ClearIn_SI(clear_in),
        .NGramShiftEN_SO(n1_shift_en), .NGramClear_SO(n1_ngram_clear), .AccumEN_SO(n1_accum_en),
        .FirstHypervector_SO(n1_first_hv), .Timeout_SO(n1_timeout), .WindowCntr_SO(n1_window_cntr),
        .State_SO(n1_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        clear_in = 1'b0;
        ready_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Table entry: {valid, clear, ready_in, timeout, ready_out, shift, accum, first, valid_out, ngram_clear}
    task automatic test_reset();
        logic [6:0] obs;
        apply_reset();
        #1;
        obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
        tests++;
        if (obs !== 7'b0100000) begin
            failures++;
            $display("FAIL reset_outputs: got %b required %b", obs, 7'b0100000);
        end
        tests++;
        if (window_cntr !== 16'd0) begin
            failures++;
            $display("FAIL reset_cntr: got %0d required 0", window_cntr);
        end
        tests++;
        if (state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d required %0d", state, IDLE);
        end
        tick();
    endtask

    task automatic test_window_basic();
        logic [9:0] tbl [0:7];
        logic [6:0] obs;
        tbl = '{10'b101_0110000, 10'b101_0110000, 10'b101_0111100, 10'b101_0111000,
                10'b101_0111000, 10'b101_0001000, 10'b101_0000011, 10'b001_0100000};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            valid_in = tbl[c][9];
            clear_in = tbl[c][8];
            ready_in = tbl[c][7];
            #1;
            obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
            tests++;
            if (obs !== tbl[c][6:0]) begin
                failures++;
                $display("FAIL window_basic c%0d: got %b required %b", c, obs, tbl[c][6:0]);
            end
            tick();
        end
        tests++;
        if (window_cntr !== 16'd1) begin
            failures++;
            $display("FAIL window_basic_cntr: got %0d required 1", window_cntr);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] tbl [0:11];
        logic [6:0] obs;
        tbl = '{10'b100_0110000, 10'b100_0110000, 10'b100_0111100, 10'b100_0111000,
                10'b100_0111000, 10'b000_0001000, 10'b000_0000010, 10'b000_0000010,
                10'b000_0000010, 10'b000_0000010, 10'b001_0000011, 10'b000_0100000};
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            valid_in = tbl[c][9];
            clear_in = tbl[c][8];
            ready_in = tbl[c][7];
            #1;
            obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
            tests++;
            if (obs !== tbl[c][6:0]) begin
                failures++;
                $display("FAIL backpressure c%0d: got %b required %b", c, obs, tbl[c][6:0]);
            end
            tick();
        end
        tests++;
        if (state !== IDLE || window_cntr !== 16'd1) begin
            failures++;
            $display("FAIL backpressure_end: state %0d cntr %0d required state %0d cntr 1",
                     state, window_cntr, IDLE);
        end
    endtask

    task automatic test_ngram1();
        logic [9:0] tbl [0:5];
        logic [6:0] obs;
        int pulses;
        tbl = '{10'b101_0110000, 10'b101_0111100, 10'b101_0111000,
                10'b001_0001000, 10'b001_0000011, 10'b001_0100000};
        pulses = 0;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            valid_in = tbl[c][9];
            clear_in = tbl[c][8];
            ready_in = tbl[c][7];
            #1;
            obs = {n1_timeout, n1_ready_out, n1_shift_en, n1_accum_en, n1_first_hv,
                   n1_valid_out, n1_ngram_clear};
            if (n1_accum_en === 1'b1) pulses++;
            tests++;
            if (obs !== tbl[c][6:0]) begin
                failures++;
                $display("FAIL ngram1 c%0d: got %b required %b", c, obs, tbl[c][6:0]);
            end
            tick();
        end
        tests++;
        if (pulses != 3 || n1_window_cntr !== 16'd1) begin
            failures++;
            $display("FAIL ngram1_totals: pulses %0d cntr %0d required pulses 3 cntr 1",
                     pulses, n1_window_cntr);
        end
    endtask

    task automatic test_clear_mid();
        logic [9:0] tbl [0:12];
        logic [6:0] obs;
        tbl = '{10'b100_0110000, 10'b100_0110000, 10'b100_0111100, 10'b110_0101001,
                10'b000_0100000, 10'b100_0110000, 10'b100_0110000, 10'b100_0111100,
                10'b100_0111000, 10'b100_0111000, 10'b000_0001000, 10'b001_0000011,
                10'b000_0100000};
        apply_reset();
        for (int c = 0; c < 13; c++) begin
            valid_in = tbl[c][9];
            clear_in = tbl[c][8];
            ready_in = tbl[c][7];
            #1;
            obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
            tests++;
            if (obs !== tbl[c][6:0]) begin
                failures++;
                $display("FAIL clear_mid c%0d: got %b required %b", c, obs, tbl[c][6:0]);
            end
            tick();
        end
        tests++;
        if (window_cntr !== 16'd1) begin
            failures++;
            $display("FAIL clear_mid_cntr: got %0d required 1", window_cntr);
        end
    endtask

    task automatic test_clear_done();
        logic [9:0] tbl [0:7];
        logic [6:0] obs;
        tbl = '{10'b100_0110000, 10'b100_0110000, 10'b100_0111100, 10'b100_0111000,
                10'b100_0111000, 10'b000_0001000, 10'b011_0000011, 10'b000_0100000};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            valid_in = tbl[c][9];
            clear_in = tbl[c][8];
            ready_in = tbl[c][7];
            #1;
            obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
            tests++;
            if (obs !== tbl[c][6:0]) begin
                failures++;
                $display("FAIL clear_done c%0d: got %b required %b", c, obs, tbl[c][6:0]);
            end
            tick();
        end
        tests++;
        if (window_cntr !== 16'd0) begin
            failures++;
            $display("FAIL clear_done_cntr: got %0d required 0", window_cntr);
        end
    endtask

    task automatic test_stall_timeout();
        logic [9:0] tbl [0:14];
        logic [9:0] win [0:7];
        logic [6:0] obs;
        for (int c = 0; c < 15; c++) tbl[c] = 10'b000_0100000;
        tbl[0] = 10'b100_0110000;
        tbl[1] = 10'b100_0110000;
        tbl[2] = 10'b000_0101100;
`ifdef TEMPORAL_TIMEOUT_EN
        tbl[9] = 10'b000_1100001;
`endif
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            valid_in = tbl[c][9];
            clear_in = tbl[c][8];
            ready_in = tbl[c][7];
            #1;
            obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
            tests++;
            if (obs !== tbl[c][6:0]) begin
                failures++;
                $display("FAIL stall c%0d: got %b required %b", c, obs, tbl[c][6:0]);
            end
            tick();
        end
`ifdef TEMPORAL_TIMEOUT_EN
        tests++;
        if (state !== IDLE || window_cntr !== 16'd0) begin
            failures++;
            $display("FAIL timeout_end: state %0d cntr %0d required state %0d cntr 0",
                     state, window_cntr, IDLE);
        end
        win = '{10'b101_0110000, 10'b101_0110000, 10'b101_0111100, 10'b101_0111000,
                10'b101_0111000, 10'b101_0001000, 10'b101_0000011, 10'b001_0100000};
        for (int c = 0; c < 8; c++) begin
            valid_in = win[c][9];
            clear_in = win[c][8];
            ready_in = win[c][7];
            #1;
            obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
            tests++;
            if (obs !== win[c][6:0]) begin
                failures++;
                $display("FAIL after_timeout c%0d: got %b required %b", c, obs, win[c][6:0]);
            end
            tick();
        end
        tests++;
        if (window_cntr !== 16'd1) begin
            failures++;
            $display("FAIL after_timeout_cntr: got %0d required 1", window_cntr);
        end
`else
        win = '{default: '0};
        tests++;
        if (state !== ACCUM || window_cntr !== 16'd0 || win[0] !== 10'd0) begin
            failures++;
            $display("FAIL stall_hold: state %0d cntr %0d required state %0d cntr 0",
                     state, window_cntr, ACCUM);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [6:0] obs;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            valid_in = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            obs = {timeout, ready_out, shift_en, accum_en, first_hv, valid_out, ngram_clear};
            tests++;
            if (obs !== 7'b0100000 || state !== IDLE) begin
                failures++;
                $display("FAIL reset_mid c%0d: got %b state %0d required 0100000 state %0d",
                         c, obs, state, IDLE);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs;
        logic [2:0] exp;
        int accs;
        accs = 0;
        apply_reset();
        valid_in = 1'b1;
        ready_in = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            exp = {(c >= 2 && c <= 5) || (c >= 9 && c <= 12), c == 2 || c == 9, c == 6 || c == 13};
            obs = {accum_en, first_hv, valid_out};
            if (accum_en === 1'b1) accs++;
            tests++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL back_to_back c%0d: got %b required %b", c, obs, exp);
            end
            tick();
        end
        valid_in = 1'b0;
        tests++;
        if (accs != 8 || window_cntr !== 16'd2) begin
            failures++;
            $display("FAIL back_to_back_totals: accums %0d cntr %0d required accums 8 cntr 2",
                     accs, window_cntr);
        end
    endtask

    task automatic test_cntr_wrap();
        apply_reset();
        force dut.window_cntr = 16'hffff;
        #1;
        release dut.window_cntr;
        tests++;
        if (window_cntr !== 16'hffff) begin
            failures++;
            $display("FAIL wrap_preload: got %h required ffff", window_cntr);
        end
        ready_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            valid_in = (c < 5);
            tick();
        end
        tests++;
        if (window_cntr !== 16'h0000) begin
            failures++;
            $display("FAIL wrap: got %h required 0000", window_cntr);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        clear_in = 1'b0;
        test_reset();
        test_window_basic();
        test_backpressure();
        test_ngram1();
        test_clear_mid();
        test_clear_done();
        test_stall_timeout();
        test_reset_mid();
        test_back_to_back();
        test_cntr_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/temporal_window_scheduler.md
Name: temporal_window_scheduler

Overview:
Control-only sequencer for the temporal encoding stage. It accepts a stream of spatial hypervector samples and splits it into fixed-length windows. For each window it drives n-gram shift/clear, accumulator enable and first-hypervector strobes to the temporal datapath, then hands the finished window hypervector to the associative memory with a valid/ready handshake. It carries no hypervector data; the datapath consumes its strobes one-for-one.

Parameters:
WINDOW_LEN, 5, samples per window; legal range WINDOW_LEN >= NGRAM_SIZE.
NGRAM_SIZE, 2, n-gram depth; legal range >= 1.
TIMEOUT_CYCLES, 1024, idle limit used only under TEMPORAL_TIMEOUT_EN.

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  reset; synchronous, active-high
ValidIn_SI  in  1  upstream sample valid
ReadyOut_SO  out  1  ready to accept a sample
ReadyIn_SI  in  1  downstream (AM) ready
ValidOut_SO  out  1  window hypervector valid
ClearIn_SI  in  1  soft abort of the current window
NGramShiftEN_SO  out  1  datapath shifts the new sample into the n-gram
NGramClear_SO  out  1  datapath zeroes the n-gram registers
AccumEN_SO  out  1  datapath accumulates the bound n-gram
FirstHypervector_SO  out  1  accumulator loads instead of adding
Timeout_SO  out  1  one-cycle abort pulse
WindowCntr_SO  out  16  completed windows; wraps at 2^16

Behaviour:
- Clock and reset: one clock, Clk_CI. Reset_RI is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - Sample index = 0. WindowCntr_SO = 0.
  - ReadyOut_SO = 1.
  - All other outputs = 0.
- Accept: ValidIn_SI && ReadyOut_SO. NGramShiftEN_SO = accept, combinational, same cycle.
- Sample index i counts accepted samples within the window: 0..WINDOW_LEN-1.
- States:
  - IDLE: ReadyOut_SO=1. On accept, go to FILL if NGRAM_SIZE>1, otherwise ACCUM.
  - FILL: ReadyOut_SO=1. Move to ACCUM once the accepted sample has i == NGRAM_SIZE-2.
  - ACCUM: ReadyOut_SO=1. The accept of i == WINDOW_LEN-1 moves to FLUSH.
  - FLUSH: ReadyOut_SO=0, lasts exactly 1 cycle, then DONE.
  - DONE: ValidOut_SO=1, ReadyOut_SO=0. On ReadyIn_SI go to IDLE, pulse NGramClear_SO, increment WindowCntr_SO and reset i.
- AccumEN_SO is registered: it pulses the cycle after the accept of any sample with i >= NGRAM_SIZE-1.
- FirstHypervector_SO accompanies only the first AccumEN_SO of a window (i == NGRAM_SIZE-1).
- Accumulations per window = WINDOW_LEN-NGRAM_SIZE+1.
- Latency: last accept at cycle t gives AccumEN_SO at t+1 and ValidOut_SO from t+2.
- Back-to-back accepts are legal: one sample per cycle with zero bubbles until FLUSH.
- ValidIn_SI low in FILL/ACCUM: hold state. No strobes.
- ClearIn_SI, any state: it has priority over accept and over the DONE handshake.
  - Next state IDLE, i = 0.
  - NGramClear_SO=1 that cycle, NGramShiftEN_SO forced 0.
  - Any pending AccumEN_SO pulse is suppressed.
  - WindowCntr_SO unchanged.
- Reset mid-window: returns to IDLE. No AccumEN_SO or ValidOut_SO is emitted afterwards.
- ValidOut_SO, once high, stays high until ReadyIn_SI is sampled or a clear/reset occurs.

Optional Feature:
TEMPORAL_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive FILL/ACCUM cycles without an accept. Any accept resets it to 0.
  - When it reaches TIMEOUT_CYCLES: Timeout_SO=1 and NGramClear_SO=1 for one cycle, then IDLE with i=0.
  - WindowCntr_SO is unchanged.
  - The watchdog is inactive in IDLE, FLUSH and DONE.
- Undefined: no watchdog logic. Timeout_SO tied to 0; the port always exists.

Decomposition:
- Shared header/package:
  - state encoding localparams IDLE, FILL, ACCUM, FLUSH, DONE;
  - ceilLog2 for counter widths;
  - default WINDOW_LEN / NGRAM_SIZE constants shared with the temporal datapath.
- One sub-module: idle_watchdog.
  - Parameter TIMEOUT_CYCLES.
  - Inputs Clk_CI, Reset_RI, Enable_SI, Kick_SI; output Expired_SO.
  - Instantiated only under TEMPORAL_TIMEOUT_EN.

Test Plan:
1. WINDOW_LEN=5, NGRAM_SIZE=2; accept samples at cycles 0-4 with ReadyIn_SI=1 -> AccumEN_SO at cycles 2,3,4,5; FirstHypervector_SO only at cycle 2; ReadyOut_SO=0 cycles 5-6; ValidOut_SO at 6; NGramClear_SO at 6; WindowCntr_SO=1.
2. Same as 1 but ReadyIn_SI held low until cycle 10 -> ValidOut_SO high cycles 6-10; ReadyOut_SO=0 throughout; IDLE at 11.
3. NGRAM_SIZE=1, WINDOW_LEN=3 -> 3 AccumEN_SO pulses; FirstHypervector_SO with the first, one cycle after the first accept.
4. ClearIn_SI asserted together with accept of sample 3 -> no AccumEN_SO next cycle; NGramClear_SO pulse; IDLE; WindowCntr_SO unchanged; next window again starts with FirstHypervector_SO.
5. With TEMPORAL_TIMEOUT_EN, TIMEOUT_CYCLES=8: accept 2 samples then stall -> Timeout_SO and NGramClear_SO pulse once 8 stalled cycles are counted; a fresh window afterwards completes normally. Without the macro -> Timeout_SO never asserts.
6. 65536 windows completed -> WindowCntr_SO wraps to 0.
